uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one multi-byte UART transmitter (24-bit payload, 1..3 bytes MSB-first)
//  among NUM_REQ requesters. Latches the winner's payload, launches the TX with a one-cycle enable, tracks
//  sending/sent, then returns a one-cycle ack. Sits between the app-level message sources and the UART TX.
// PARAMETERS
//  NUM_REQ         4     number of requesters (2..8)
//  DATA_W          24    payload width, fixed by the TX datapath
//  BYTES_W         3     byte-count width
//  TIMEOUT_CYCLES  1024  watchdog limit, used only with UART_TX_ARB_TIMEOUT_EN
// PORTS
//  clk         in   1                  system clock, all logic on posedge
//  reset       in   1                  synchronous, active-high reset
//  req         in   NUM_REQ            level request per requester, held until its ack
//  req_data    in   NUM_REQ*DATA_W     payload of requester i at [i*DATA_W +: DATA_W], stable while req[i]=1
//  req_bytes   in   NUM_REQ*BYTES_W    byte count of requester i at [i*BYTES_W +: BYTES_W], valid 1..3
//  ack         out  NUM_REQ            one-cycle pulse on completion (or rejection) of requester i
//  err         out  1                  qualifies ack: 1 = rejected/aborted, 0 = transmitted
//  busy        out  1                  high from grant until ack cycle inclusive
//  grant_id    out  $clog2(NUM_REQ)    index of current/last granted requester
//  tx_data     out  DATA_W             registered payload to TX
//  tx_bytes    out  BYTES_W            registered byte count to TX
//  tx_ena      out  1                  one-cycle launch strobe to TX (TX starts on its rising edge)
//  tx_sending  in   1                  TX busy flag
//  tx_sent     in   1                  TX done flag (level, stays high until next launch)
// BEHAVIOUR
//  Reset: ack=0, err=0, busy=0, grant_id=0, tx_data=0, tx_bytes=0, tx_ena=0, rr pointer=0, state=IDLE.
//  FSM IDLE -> LAUNCH -> WAIT_START -> WAIT_DONE -> ACK -> IDLE.
//  IDLE: when |req and tx_sending==0, pick winner = first set req at or after rr pointer (wrapping);
//   register grant_id, tx_data, tx_bytes; busy=1. If winner's req_bytes is 0 or >3: go ACK with err=1, no launch.
//  LAUNCH: tx_ena=1 for exactly this cycle -> WAIT_START.
//  WAIT_START: tx_ena=0; on tx_sending==1 -> WAIT_DONE.
//  WAIT_DONE: on tx_sending==0 && tx_sent==1 -> ACK.
//  ACK: ack[grant_id]=1, err as determined, busy=1; rr pointer <= grant_id+1 (mod NUM_REQ); -> IDLE (busy=0).
//  Latency: grant to tx_ena = 1 cycle; earliest re-grant is the cycle after ACK, so tx_ena is low >=3 cycles
//   between launches (TX edge detect satisfied).
//  tx_data/tx_bytes held constant from grant until next grant; req changes during service are ignored.
//  Requester keeping req high after ack is re-queued behind others (fairness via pointer).
//  Simultaneous requests: strict rotation, no requester waits more than NUM_REQ-1 services.
//  Reset mid-transfer: FSM to IDLE, no ack issued for aborted grant; TX has no reset, so IDLE blocks
//   grants until tx_sending==0.
// CONFIGURATION
//  UART_TX_ARB_TIMEOUT_EN defined: cycle counter cleared at LAUNCH, counts in WAIT_START/WAIT_DONE;
//   reaching TIMEOUT_CYCLES -> ACK with err=1. Next grant still waits for tx_sending==0.
//  Not defined: no counter; FSM waits indefinitely; err only flags illegal byte count.
// STRUCTURE
//  Package uart_tx_pkg: state enum (IDLE, LAUNCH, WAIT_START, WAIT_DONE, ACK), DATA_W=24,
//   BYTES_MAX=3, BYTES_W=3 constants shared with the TX block.
//  Sub-module rr_arbiter: NUM_REQ-wide round-robin picker (req, pointer in -> one-hot grant, index, any).
// TESTING (TX model SAMPLING_RATE=16: 152 clocks/byte)
//  1. Single req[0], data 24'hA1B2C3, bytes=3 -> one tx_ena pulse, bytes A1,B2,C3 on line, ack[0] ~456 clks later, err=0.
//  2. req=4'b1111 same cycle, bytes=1 each -> grants 0,1,2,3 in order, exactly one ack each, no overlap.
//  3. req[2] held high after ack while req[0] asserts -> next grant is 3 then 0, pointer wrap verified.
//  4. req[1] with bytes=0 and bytes=5 -> ack[1] with err=1 after 2 cycles, tx_ena never pulses.
//  5. reset pulsed mid-byte-2 of a 3-byte send -> no ack; new req granted only after tx_sending falls.
//  6. UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, TX model tx_sending stuck 0 -> ack with err=1 at 64 cycles after launch.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared UART TX constants and arbiter state encoding
package uart_tx_pkg;

  localparam int DATA_W    = 24;
  localparam int BYTES_MAX = 3;
  localparam int BYTES_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE,
    ACK
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first set request at or after pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  always_comb begin
    int k;
    grant = '0;
    index = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(pointer) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any      = 1'b1;
        index    = IDX_W'(k);
        grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sequencer sharing one multi-byte UART TX among requesters
// Optional watchdog: UART_TX_ARB_TIMEOUT_EN
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 24,
  parameter int BYTES_W        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ*BYTES_W-1:0]   req_bytes,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         err,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [DATA_W-1:0]            tx_data,
  output logic [BYTES_W-1:0]           tx_bytes,
  output logic                         tx_ena,
  input  logic                         tx_sending,
  input  logic                         tx_sent
);

  localparam int ID_W = $clog2(NUM_REQ);

  uart_tx_pkg::state_t state, state_n;

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] win_grant;
  logic [ID_W-1:0]    win_index;
  logic               win_any;
  logic [DATA_W-1:0]  win_data;
  logic [BYTES_W-1:0] win_bytes;
  logic               bytes_ok;
  logic               grant_go;
  logic               err_q;
  logic               timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .req     (req),
    .pointer (rr_ptr),
    .grant   (win_grant),
    .index   (win_index),
    .any     (win_any)
  );

  always_comb begin
    win_data  = '0;
    win_bytes = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        win_data  = req_data[i*DATA_W +: DATA_W];
        win_bytes = req_bytes[i*BYTES_W +: BYTES_W];
      end
    end
  end

  assign bytes_ok = (win_bytes != '0) && (win_bytes <= BYTES_W'(uart_tx_pkg::BYTES_MAX));
  // The TX has no reset, so a transfer orphaned by our reset must drain before any new grant.
  assign grant_go = (state == uart_tx_pkg::IDLE) && win_any && !tx_sending;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (state == uart_tx_pkg::LAUNCH) begin
      timer <= '0;
    end else if (state == uart_tx_pkg::WAIT_START || state == uart_tx_pkg::WAIT_DONE) begin
      timer <= timer + 1'b1;
    end
  end

  assign timeout = (state == uart_tx_pkg::WAIT_START || state == uart_tx_pkg::WAIT_DONE) &&
                   (timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= uart_tx_pkg::IDLE;
      grant_id <= '0;
      tx_data  <= '0;
      tx_bytes <= '0;
      err_q    <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      state <= state_n;
      if (grant_go) begin
        grant_id <= win_index;
        tx_data  <= win_data;
        tx_bytes <= win_bytes;
        err_q    <= !bytes_ok;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
      if (state == uart_tx_pkg::ACK) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    ack     = '0;
    err     = 1'b0;
    busy    = 1'b1;
    tx_ena  = 1'b0;
    case (state)
      uart_tx_pkg::IDLE: begin
        busy = 1'b0;
        if (grant_go) begin
          state_n = bytes_ok ? uart_tx_pkg::LAUNCH : uart_tx_pkg::ACK;
        end
      end
      uart_tx_pkg::LAUNCH: begin
        tx_ena  = 1'b1;
        state_n = uart_tx_pkg::WAIT_START;
      end
      uart_tx_pkg::WAIT_START: begin
        if (timeout)         state_n = uart_tx_pkg::ACK;
        else if (tx_sending) state_n = uart_tx_pkg::WAIT_DONE;
      end
      uart_tx_pkg::WAIT_DONE: begin
        if (timeout)                      state_n = uart_tx_pkg::ACK;
        else if (!tx_sending && tx_sent)  state_n = uart_tx_pkg::ACK;
      end
      uart_tx_pkg::ACK: begin
        ack[grant_id] = 1'b1;
        err           = err_q;
        state_n       = uart_tx_pkg::IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = uart_tx_pkg::IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural UART TX model
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 24;
  localparam int BW  = 3;
  localparam int CPB = 152;

  typedef struct {
    int   id;
    logic err;
  } ack_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic [BW-1:0] bytes;
  } launch_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N*BW-1:0] req_bytes;
  logic [N-1:0]    ack;
  logic            err;
  logic            busy;
  logic [1:0]      grant_id;
  logic [DW-1:0]   tx_data;
  logic [BW-1:0]   tx_bytes;
  logic            tx_ena;
  logic            tx_sending;
  logic            tx_sent;

  logic [N-1:0] hold;
  logic         tx_stuck;
  int           checks = 0;
  int           errors = 0;
  int           launches = 0;
  ack_t         ack_q[$];
  launch_t      launch_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .DATA_W         (DW),
    .BYTES_W        (BW),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_bytes  (req_bytes),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .grant_id   (grant_id),
    .tx_data    (tx_data),
    .tx_bytes   (tx_bytes),
    .tx_ena     (tx_ena),
    .tx_sending (tx_sending),
    .tx_sent    (tx_sent)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // TX model: launches on tx_ena rising edge, busy CPB clocks per byte, sent is a level.
  initial begin
    logic ena_prev;
    int   cnt;
    ena_prev   = 1'b0;
    cnt        = 0;
    tx_sending = 1'b0;
    tx_sent    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!tx_stuck) begin
        if (tx_ena && !ena_prev) begin
          tx_sending = 1'b1;
          tx_sent    = 1'b0;
          cnt        = int'(tx_bytes) * CPB;
        end else if (tx_sending) begin
          cnt--;
          if (cnt == 0) begin
            tx_sending = 1'b0;
            tx_sent    = 1'b1;
          end
        end
      end
      ena_prev = tx_ena;
    end
  end

  // Monitor: pops expectations whenever the DUT launches or acks.
  initial begin
    logic    prev_sending;
    ack_t    a;
    launch_t l;
    prev_sending = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tx_ena) begin
          launches++;
          check("launch_while_tx_idle", prev_sending, 1'b0);
          check("launch_expected", launch_q.size() > 0, 1'b1);
          if (launch_q.size() > 0) begin
            l = launch_q.pop_front();
            check("launch_grant_id", grant_id, l.id);
            check("launch_tx_data", tx_data, l.data);
            check("launch_tx_bytes", tx_bytes, l.bytes);
          end
        end
        if (ack != '0) begin
          check("ack_onehot", $countones(ack), 1);
          check("ack_busy", busy, 1'b1);
          check("ack_expected", ack_q.size() > 0, 1'b1);
          if (ack_q.size() > 0) begin
            a = ack_q.pop_front();
            check("ack_vector", ack, 32'd1 << a.id);
            check("ack_err", err, a.err);
          end
        end
      end
      prev_sending = tx_sending;
    end
  end

  // Every stimulus wait goes through here so requesters drop req on their ack.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        if (hold[i]) hold[i] = 1'b0;
        else         req[i]  = 1'b0;
      end
    end
  endtask

  task automatic raise(input int id, input logic [DW-1:0] d, input logic [BW-1:0] b);
    req_data[id*DW +: DW]  = d;
    req_bytes[id*BW +: BW] = b;
    req[id]                = 1'b1;
  endtask

  task automatic post(input int id, input logic [DW-1:0] d, input logic [BW-1:0] b,
                      input logic e, input bit with_launch, input bit with_ack);
    launch_t l;
    ack_t    a;
    l.id = id; l.data = d; l.bytes = b;
    a.id = id; a.err = e;
    if (with_launch) launch_q.push_back(l);
    if (with_ack)    ack_q.push_back(a);
  endtask

  task automatic wait_launch(output int cyc);
    cyc = 0;
    do begin
      cycle();
      cyc++;
    end while (!tx_ena && cyc < 2000);
    check("launch_seen", tx_ena, 1'b1);
  endtask

  task automatic wait_ack(input int id, output int cyc);
    cyc = 0;
    do begin
      cycle();
      cyc++;
    end while (!ack[id] && cyc < 2000);
    check("ack_seen", ack[id], 1'b1);
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    do begin
      cycle();
      cyc++;
    end while ((ack_q.size() != 0 || busy) && cyc < 4000);
    check("drain_ack_queue", ack_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold  = '0;
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int l0;
    reset     = 1'b1;
    req       = '0;
    req_data  = '0;
    req_bytes = '0;
    hold      = '0;
    tx_stuck  = 1'b0;
    repeat (3) cycle();
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_bytes", tx_bytes, 0);
    check("rst_tx_ena", tx_ena, 0);
    reset = 1'b0;

    // single 3-byte transfer
    raise(0, 24'hA1B2C3, 3'd3);
    post(0, 24'hA1B2C3, 3'd3, 1'b0, 1, 1);
    wait_launch(c);
    wait_ack(0, c);
    check_range("t1_launch_to_ack", c, 455, 460);
    wait_drain();

    // four simultaneous 1-byte requests serviced in index order
    do_reset();
    for (int i = 0; i < N; i++) begin
      raise(i, 24'h5A0000 | 24'(i), 3'd1);
      post(i, 24'h5A0000 | 24'(i), 3'd1, 1'b0, 1, 1);
    end
    l0 = launches;
    wait_drain();
    check("t2_launch_count", launches - l0, 4);

    // requester 2 re-queues behind 3 and 0 (pointer wrap)
    do_reset();
    hold[2] = 1'b1;
    raise(2, 24'hC0FFEE, 3'd1);
    post(2, 24'hC0FFEE, 3'd1, 1'b0, 1, 1);
    wait_launch(c);
    raise(3, 24'h333333, 3'd2);
    raise(0, 24'h000AAA, 3'd1);
    post(3, 24'h333333, 3'd2, 1'b0, 1, 1);
    post(0, 24'h000AAA, 3'd1, 1'b0, 1, 1);
    post(2, 24'hC0FFEE, 3'd1, 1'b0, 1, 1);
    wait_drain();

    // illegal byte counts are rejected without a launch
    l0 = launches;
    raise(1, 24'h123456, 3'd0);
    post(1, 24'h123456, 3'd0, 1'b1, 0, 1);
    wait_ack(1, c);
    check_range("t4_reject_latency_b0", c, 1, 2);
    raise(1, 24'h654321, 3'd5);
    post(1, 24'h654321, 3'd5, 1'b1, 0, 1);
    wait_ack(1, c);
    check_range("t4_reject_latency_b5", c, 1, 2);
    wait_drain();
    check("t4_no_launch", launches - l0, 0);

    // reset in the middle of byte 2: no ack, next grant waits for the TX to drain
    do_reset();
    raise(0, 24'h112233, 3'd3);
    post(0, 24'h112233, 3'd3, 1'b0, 1, 0);
    wait_launch(c);
    repeat (CPB + 76) cycle();
    reset = 1'b1;
    req   = '0;
    cycle();
    reset = 1'b0;
    raise(1, 24'h445566, 3'd2);
    post(1, 24'h445566, 3'd2, 1'b0, 1, 1);
    repeat (5) cycle();
    check("t5_blocked_while_tx_busy", busy, 1'b0);
    wait_launch(c);
    wait_drain();

`ifdef UART_TX_ARB_TIMEOUT_EN
    // TX never responds: watchdog aborts with err
    tx_stuck = 1'b1;
    raise(3, 24'hDEAD01, 3'd1);
    post(3, 24'hDEAD01, 3'd1, 1'b1, 1, 1);
    wait_launch(c);
    wait_ack(3, c);
    check_range("t6_timeout_latency", c, 64, 66);
    wait_drain();
    tx_stuck = 1'b0;
`endif

    repeat (4) cycle();
    check("end_ack_queue_empty", ack_q.size(), 0);
    check("end_launch_queue_empty", launch_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
